nunchuk_reader: RTL and testbench
=================================

Name: nunchuk_reader

Overview:
- I2C master that initialises a Wii Nunchuk and polls it continuously.
- Produces the 48-bit `wii_data` word that the game control logic consumes, e.g. `wii_data[4]` drives bullet fire.
- Runs in the 100 MHz `clock` domain from PLL100MHz.
- Drives the open-drain SCL/SDA pads through output-enable signals only.

Parameters:
- CLK_FREQ, 100000000: `clock` frequency in Hz.
- I2C_FREQ, 100000: SCL bit rate in Hz. QDIV = CLK_FREQ/(4*I2C_FREQ) clocks per quarter-bit (250 at default).
- DEV_ADDR, 7'h52: Nunchuk 7-bit slave address.
- POWERUP_CYCLES, 2000000: idle delay after reset before first transaction (20 ms).
- CONV_CYCLES, 100000: delay between conversion-request write and data read (1 ms).
- POLL_CYCLES, 1000000: delay from end of one read to next conversion request (10 ms).

Ports:
- clock, input, 1: system clock.
- reset, input, 1: synchronous, active-high.
- scl_oe, output, 1: 1 = pull SCL low, 0 = release (pad pulled high externally).
- sda_oe, output, 1: 1 = pull SDA low, 0 = release.
- sda_in, input, 1: sampled SDA pad level (already synchronised upstream).
- wii_data, output, 48: last good sample. Byte0 (joy X) at [47:40] … byte5 at [7:0].
- data_valid, output, 1: one-cycle pulse when `wii_data` updates.
- error, output, 1: set on any NACK; cleared by the next successful read.

Behaviour:
- Reset values:
  - `scl_oe` = 0, `sda_oe` = 0.
  - `wii_data` = 48'h0, `data_valid` = 0, `error` = 0.
  - FSM in POWERUP, quarter counter = 0.
- Reset mid-transfer: both lines released on the next edge; no STOP is generated.
- Quarter-bit tick: counter 0..QDIV-1. The FSM advances only on the tick. Each bit occupies 4 quarters, SCL low/low/high/high.
  - Master drives SDA at quarter 0.
  - Master samples `sda_in` at quarter 2, mid SCL-high.
- START: SDA released, SCL released, then SDA falls while SCL is high, then SCL falls (4 quarters).
- STOP: SDA low, SCL rises, then SDA rises while SCL is high (4 quarters).
- Bytes are sent MSB first.
  - Write: after 8 bits, SDA is released for the ACK bit. `sda_in` = 1 at sample is a NACK.
  - Read: after 8 bits, master drives ACK (SDA low) for bytes 0-4 and NACK (released) for byte 5.
- Transaction sequence (FSM states POWERUP, INIT1, INIT2, CONV_REQ, CONV_WAIT, READ, POLL_WAIT, FAULT):
  - POWERUP: wait POWERUP_CYCLES.
  - INIT1: START, {DEV_ADDR,0}, 8'hF0, 8'h55, STOP.
  - INIT2: START, {DEV_ADDR,0}, 8'hFB, 8'h00, STOP.
  - CONV_REQ: START, {DEV_ADDR,0}, 8'h00, STOP.
  - CONV_WAIT: wait CONV_CYCLES.
  - READ: START, {DEV_ADDR,1}, 6 data bytes, STOP.
  - POLL_WAIT: wait POLL_CYCLES, then go to CONV_REQ. POWERUP and INIT are not repeated.
- Read capture:
  - Received bytes go into a shadow register. `wii_data` is loaded only after STOP of a complete 6-byte read.
  - Byte5 bits [1:0] (C, Z) are inverted on load, so buttons are active-high in `wii_data`.
  - `data_valid` pulses in the same cycle that `wii_data` loads. `error` is cleared in that same cycle.
- NACK on any address or write byte:
  - Abort remaining bytes, generate STOP, set `error` = 1.
  - Proceed according to the optional feature below.
  - `wii_data` holds its previous value; `data_valid` stays 0.
- The master never drives SDA high. No clock stretching; SCL is treated as master-owned.

Optional Feature:
- Macro NUNCHUK_RETRY_EN.
- Defined: after a NACK's STOP, FSM returns to POWERUP and reruns the full init sequence. Polling resumes once init succeeds. `error` stays 1 until the next good read.
- Undefined: after a NACK's STOP, FSM enters FAULT and stays there with both lines released until reset.

Test Plan:
- Use CLK_FREQ=400, I2C_FREQ=100 (QDIV=1), POWERUP/CONV/POLL_CYCLES=10, with an I2C slave model at address 0x52.
- Reset released → first START after 10 cycles. Bus shows writes A4 F0 55, A4 FB 00, A4 00, then read A5 with master ACK ×5 and NACK ×1; every write byte is ACKed by the slave.
- Slave returns 7F 80 12 34 56 FC on the read → `wii_data` = 48'h7F80123456FF, with one `data_valid` pulse after STOP; `error` = 0.
- Second poll, slave returns 00 00 00 00 00 03 → `wii_data` = 48'h000000000000. Check exactly POLL_CYCLES idle between the first read's STOP and the second request's START.
- Slave NACKs address A4 during INIT1 → STOP follows, `error` = 1, `wii_data` unchanged.
  - Without the macro: SCL and SDA stay released for ≥1000 cycles.
  - With NUNCHUK_RETRY_EN: INIT1 restarts after POWERUP_CYCLES.
- Assert reset in the middle of READ byte 3 → next cycle `scl_oe` = `sda_oe` = 0, `wii_data` = 0, then the POWERUP sequence restarts.

Source files
------------

// File: rtl/nunchuk_reader.sv
// I2C master that initialises a Wii Nunchuk, then polls its 6-byte report into wii_data.
// Define NUNCHUK_RETRY_EN to rerun power-up and init after a NACK instead of parking in FAULT.
module nunchuk_reader #(
    parameter int         CLK_FREQ       = 100000000,
    parameter int         I2C_FREQ       = 100000,
    parameter logic [6:0] DEV_ADDR       = 7'h52,
    parameter int         POWERUP_CYCLES = 2000000,
    parameter int         CONV_CYCLES    = 100000,
    parameter int         POLL_CYCLES    = 1000000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        sda_in,
    output logic [47:0] wii_data,
    output logic        data_valid,
    output logic        error
);
    localparam int QDIV = CLK_FREQ / (4 * I2C_FREQ);
    localparam int QW   = (QDIV > 1) ? $clog2(QDIV) : 1;

    typedef enum logic [2:0] {
        POWERUP, INIT1, INIT2, CONV_REQ, CONV_WAIT, READ, POLL_WAIT, FAULT
    } state_t;
    typedef enum logic [1:0] {PH_IDLE, PH_START, PH_BYTE, PH_STOP} phase_t;

    state_t        state, state_nxt;
    phase_t        phase, phase_nxt;
    logic [QW-1:0] qcnt;
    logic          tick;
    logic [1:0]    qpos, qpos_nxt;
    logic [3:0]    bit_idx, bit_idx_nxt;
    logic [2:0]    byte_idx, byte_idx_nxt;
    logic [31:0]   wait_cnt, wait_cnt_nxt, wait_lim;
    logic          aborted, aborted_nxt;
    logic          ack_bit;
    logic [7:0]    shift;
    logic [47:0]   shadow;
    logic [7:0]    tx_byte;
    logic [2:0]    last_byte;
    logic          rd_data;
    logic          sample_en, byte_done, nack, load;

    assign tick    = (qcnt == QW'(QDIV - 1));
    assign rd_data = (state == READ) && (byte_idx != 3'd0);

    always_comb begin
        tx_byte   = 8'h00;
        last_byte = 3'd2;
        wait_lim  = 32'(POLL_CYCLES);
        case (state)
            INIT1:     tx_byte = (byte_idx == 3'd1) ? 8'hF0 : 8'h55;
            INIT2:     tx_byte = (byte_idx == 3'd1) ? 8'hFB : 8'h00;
            CONV_REQ:  last_byte = 3'd1;
            READ:      last_byte = 3'd6;
            POWERUP:   wait_lim = 32'(POWERUP_CYCLES);
            CONV_WAIT: wait_lim = 32'(CONV_CYCLES);
            default:   ;
        endcase
        if (byte_idx == 3'd0)
            tx_byte = {DEV_ADDR, state == READ};
    end

    always_comb begin
        state_nxt    = state;
        phase_nxt    = phase;
        qpos_nxt     = qpos;
        bit_idx_nxt  = bit_idx;
        byte_idx_nxt = byte_idx;
        wait_cnt_nxt = wait_cnt;
        aborted_nxt  = aborted;
        sample_en    = 1'b0;
        byte_done    = 1'b0;
        nack         = 1'b0;
        load         = 1'b0;
        case (state)
            POWERUP, CONV_WAIT, POLL_WAIT: begin
                wait_cnt_nxt = wait_cnt + 32'd1;
                if (tick && wait_cnt >= wait_lim - 32'd1) begin
                    wait_cnt_nxt = 32'd0;
                    phase_nxt    = PH_START;
                    qpos_nxt     = 2'd0;
                    state_nxt    = (state == POWERUP)   ? INIT1 :
                                   (state == CONV_WAIT) ? READ  : CONV_REQ;
                end
            end
            INIT1, INIT2, CONV_REQ, READ: if (tick) begin
                qpos_nxt = qpos + 2'd1;
                case (phase)
                    PH_START: if (qpos == 2'd3) begin
                        phase_nxt    = PH_BYTE;
                        bit_idx_nxt  = 4'd0;
                        byte_idx_nxt = 3'd0;
                    end
                    PH_BYTE: begin
                        sample_en = (qpos == 2'd2);
                        if (qpos == 2'd3) begin
                            if (bit_idx != 4'd8) begin
                                bit_idx_nxt = bit_idx + 4'd1;
                            end else begin
                                // End of the ACK slot: a released SDA on a write byte is a NACK.
                                bit_idx_nxt = 4'd0;
                                byte_done   = rd_data;
                                if (!rd_data && ack_bit) begin
                                    nack        = 1'b1;
                                    aborted_nxt = 1'b1;
                                    phase_nxt   = PH_STOP;
                                end else if (byte_idx == last_byte) begin
                                    phase_nxt = PH_STOP;
                                end else begin
                                    byte_idx_nxt = byte_idx + 3'd1;
                                end
                            end
                        end
                    end
                    PH_STOP: if (qpos == 2'd3) begin
                        phase_nxt   = PH_IDLE;
                        aborted_nxt = 1'b0;
                        if (aborted) begin
`ifdef NUNCHUK_RETRY_EN
                            state_nxt = POWERUP;
`else
                            state_nxt = FAULT;
`endif
                        end else begin
                            case (state)
                                INIT1:    begin state_nxt = INIT2;    phase_nxt = PH_START; end
                                INIT2:    begin state_nxt = CONV_REQ; phase_nxt = PH_START; end
                                CONV_REQ: state_nxt = CONV_WAIT;
                                default:  begin state_nxt = POLL_WAIT; load = 1'b1; end
                            endcase
                        end
                    end
                    default: phase_nxt = PH_START;
                endcase
            end
            default: ;
        endcase
    end

    // Line drive is a pure decode of registered state, so reset releases both lines at once.
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (phase)
            PH_START: begin
                scl_oe = (qpos == 2'd3);
                sda_oe = qpos[1];
            end
            PH_BYTE: begin
                scl_oe = !qpos[1];
                if (rd_data)
                    sda_oe = (bit_idx == 4'd8) && (byte_idx != 3'd6);
                else
                    sda_oe = (bit_idx != 4'd8) && !tx_byte[3'd7 - bit_idx[2:0]];
            end
            PH_STOP: begin
                scl_oe = (qpos == 2'd0);
                sda_oe = !qpos[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= POWERUP;
            phase    <= PH_IDLE;
            qcnt     <= '0;
            qpos     <= 2'd0;
            bit_idx  <= 4'd0;
            byte_idx <= 3'd0;
            wait_cnt <= 32'd0;
            aborted  <= 1'b0;
        end else begin
            state    <= state_nxt;
            phase    <= phase_nxt;
            qcnt     <= tick ? '0 : qcnt + 1'b1;
            qpos     <= qpos_nxt;
            bit_idx  <= bit_idx_nxt;
            byte_idx <= byte_idx_nxt;
            wait_cnt <= wait_cnt_nxt;
            aborted  <= aborted_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ack_bit    <= 1'b0;
            shift      <= 8'h00;
            shadow     <= 48'h0;
            wii_data   <= 48'h0;
            data_valid <= 1'b0;
            error      <= 1'b0;
        end else begin
            data_valid <= load;
            if (sample_en) begin
                if (bit_idx == 4'd8)
                    ack_bit <= sda_in;
                else
                    shift <= {shift[6:0], sda_in};
            end
            if (byte_done)
                shadow <= {shadow[39:0], shift};
            if (nack)
                error <= 1'b1;
            // C and Z arrive active-low; present them active-high.
            if (load) begin
                wii_data <= {shadow[47:2], ~shadow[1:0]};
                error    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_nunchuk_reader.sv
// Bench for nunchuk_reader: bus-level slave model at 0x52, byte scoreboard and read-vector table.
module tb_nunchuk_reader;
    localparam int POWERUP = 10;
    localparam int CONV    = 10;
    localparam int POLL    = 10;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        scl_oe, sda_oe, sda_in, data_valid, error;
    logic [47:0] wii_data;
    logic        scl_bus, sda_bus;
    logic        slv_oe = 1'b0;

    assign scl_bus = ~scl_oe;
    assign sda_bus = ~sda_oe & ~slv_oe;
    assign sda_in  = sda_bus;

    nunchuk_reader #(
        .CLK_FREQ(400), .I2C_FREQ(100), .DEV_ADDR(7'h52),
        .POWERUP_CYCLES(POWERUP), .CONV_CYCLES(CONV), .POLL_CYCLES(POLL)
    ) dut (
        .clock(clock), .reset(reset), .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_in(sda_in),
        .wii_data(wii_data), .data_valid(data_valid), .error(error)
    );

    always #5 clock = ~clock;

    // Slave model state; bytes seen on the bus are logged as {byte, ack level}.
    logic        prev_scl = 1'b1, prev_sda = 1'b1;
    logic        active = 1'b0, is_addr = 1'b0, tx_mode = 1'b0, rd_req = 1'b0, m_ack = 1'b0;
    logic [7:0]  rx = 8'h00;
    int          nbit = 0, tx_idx = 0, stop_cnt = 0, obs_wr = 0;
    logic [8:0]  obs_mem[512];
    logic [47:0] slv_word = 48'h0;
    logic        nack_addr = 1'b0;
    int          dv_cnt = 0;

    always @(negedge clock) begin
        if (reset) begin
            slv_oe = 1'b0; active = 1'b0; tx_mode = 1'b0; nbit = 0;
            prev_scl = 1'b1; prev_sda = 1'b1;
        end else begin
            if (prev_scl && scl_bus && prev_sda && !sda_bus) begin
                active = 1'b1; is_addr = 1'b1; tx_mode = 1'b0; rd_req = 1'b0; nbit = 0; slv_oe = 1'b0;
            end else if (prev_scl && scl_bus && !prev_sda && sda_bus) begin
                active = 1'b0; tx_mode = 1'b0; slv_oe = 1'b0; stop_cnt++;
            end else if (active && !prev_scl && scl_bus) begin
                if (nbit < 8) begin
                    if (!tx_mode) rx = {rx[6:0], sda_bus};
                end else begin
                    if (tx_mode) begin
                        obs_mem[obs_wr % 512] = {slv_word[8*(5-tx_idx) +: 8], sda_bus};
                        m_ack = sda_bus;
                    end else begin
                        obs_mem[obs_wr % 512] = {rx, sda_bus};
                    end
                    obs_wr++;
                end
                nbit++;
            end else if (active && prev_scl && !scl_bus) begin
                if (nbit == 8) begin
                    if (tx_mode) slv_oe = 1'b0;
                    else if (is_addr) begin
                        slv_oe = !nack_addr && (rx[7:1] == 7'h52);
                        rd_req = rx[0] && (rx[7:1] == 7'h52);
                    end else slv_oe = 1'b1;
                end else if (nbit == 9) begin
                    nbit = 0; slv_oe = 1'b0;
                    if (tx_mode) begin
                        if (!m_ack && tx_idx < 5) begin
                            tx_idx++;
                            slv_oe = !slv_word[8*(5-tx_idx) + 7];
                        end else tx_mode = 1'b0;
                    end else if (is_addr && rd_req && slv_oe == 1'b0) begin
                        tx_mode = 1'b1; tx_idx = 0;
                        slv_oe = !slv_word[47];
                    end
                    is_addr = 1'b0;
                end else if (tx_mode && nbit >= 1 && nbit <= 7) begin
                    slv_oe = !slv_word[8*(5-tx_idx) + 7 - nbit];
                end
            end
            prev_scl = scl_bus;
            prev_sda = sda_bus;
        end
    end

    always @(negedge clock) if (data_valid === 1'b1) dv_cnt++;

    typedef struct {
        logic [47:0] rx;
        logic [47:0] exp;
    } vec_t;
    vec_t        vecs[4];
    logic [8:0]  exp_q[$];
    int          obs_rd = 0;
    int          n_vec = 0, n_fail = 0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push_init();
        exp_q.push_back({8'hA4, 1'b0}); exp_q.push_back({8'hF0, 1'b0}); exp_q.push_back({8'h55, 1'b0});
        exp_q.push_back({8'hA4, 1'b0}); exp_q.push_back({8'hFB, 1'b0}); exp_q.push_back({8'h00, 1'b0});
    endtask

    task automatic push_poll(input logic [47:0] data);
        exp_q.push_back({8'hA4, 1'b0}); exp_q.push_back({8'h00, 1'b0});
        exp_q.push_back({8'hA5, 1'b0});
        for (int k = 0; k < 6; k++)
            exp_q.push_back({data[8*(5-k) +: 8], k == 5});
    endtask

    task automatic drain_bus(input string tag);
        logic [8:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_rd >= obs_wr) begin
                n_vec++; n_fail++;
                $display("FAIL %s_bus: got no byte, required %h", tag, e);
            end else begin
                check({tag, "_bus"}, 48'(obs_mem[obs_rd % 512]), 48'(e));
                obs_rd++;
            end
        end
        check({tag, "_bus_extra"}, 48'(obs_wr - obs_rd), 48'd0);
        obs_rd = obs_wr;
    endtask

    task automatic wait_sda(output int n);
        n = 0;
        while (n < 5000) begin
            @(posedge clock); #1; n++;
            if (sda_oe === 1'b1) break;
        end
    endtask

    task automatic wait_dv(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(posedge clock); #1;
            if (data_valid === 1'b1) ok = 1'b1;
        end
    endtask

    initial begin
        int   n, dv_before, stop_before, busy;
        logic ok;
        vecs[0] = '{48'h7F80123456FC, 48'h7F80123456FF};
        vecs[1] = '{48'h000000000003, 48'h000000000000};
        vecs[2] = '{48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFC};
        vecs[3] = '{48'hA55AC33C0102, 48'hA55AC33C0101};

        repeat (3) @(posedge clock);
        #1;
        check("rst_scl_oe", 48'(scl_oe), 48'd0);
        check("rst_sda_oe", 48'(sda_oe), 48'd0);
        check("rst_wii_data", wii_data, 48'h0);
        check("rst_data_valid", 48'(data_valid), 48'd0);
        check("rst_error", 48'(error), 48'd0);
        @(negedge clock) reset = 1'b0;
        // START spends two released quarters before SDA falls.
        wait_sda(n);
        check("powerup_start", 48'(n), 48'(POWERUP + 2));

        for (int v = 0; v < 4; v++) begin
            slv_word = vecs[v].rx;
            if (v == 0) push_init();
            push_poll(vecs[v].rx);
            dv_before = dv_cnt;
            wait_dv(ok);
            check("dv_seen", 48'(ok), 48'd1);
            drain_bus("poll");
            check("wii_data", wii_data, vecs[v].exp);
            check("error_clear", 48'(error), 48'd0);
            if (v == 0) check("stop_count", 48'(stop_cnt), 48'd4);
            // data_valid rises on the edge that ends STOP; POLL idle cycles then two START quarters.
            wait_sda(n);
            check("poll_gap", 48'(n), 48'(POLL + 2));
            check("dv_pulses", 48'(dv_cnt), 48'(dv_before + 1));
        end

        // Reset in the middle of data byte 3 of the next read.
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clock);
            if (tx_mode && tx_idx == 3) ok = 1'b1;
        end
        check("reach_byte3", 48'(ok), 48'd1);
        reset = 1'b1;
        nack_addr = 1'b1;
        @(posedge clock); #1;
        check("midrst_scl_oe", 48'(scl_oe), 48'd0);
        check("midrst_sda_oe", 48'(sda_oe), 48'd0);
        check("midrst_wii_data", wii_data, 48'h0);
        check("midrst_data_valid", 48'(data_valid), 48'd0);
        exp_q.delete();
        @(negedge clock) reset = 1'b0;
        obs_rd = obs_wr;
        stop_before = stop_cnt;
        dv_before = dv_cnt;
        wait_sda(n);
        check("restart_start", 48'(n), 48'(POWERUP + 2));

        // Slave NACKs the INIT1 address.
        exp_q.push_back({8'hA4, 1'b1});
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(posedge clock); #1;
            if (error === 1'b1) ok = 1'b1;
        end
        check("nack_error", 48'(ok), 48'd1);
        drain_bus("nack");
        check("nack_wii_data", wii_data, 48'h0);
`ifdef NUNCHUK_RETRY_EN
        nack_addr = 1'b0;
        // Four STOP quarters, POWERUP wait, then two START quarters.
        wait_sda(n);
        check("retry_start", 48'(n), 48'(POWERUP + 6));
        check("nack_stop", 48'(stop_cnt), 48'(stop_before + 1));
        check("nack_no_dv", 48'(dv_cnt), 48'(dv_before));
        check("retry_error_held", 48'(error), 48'd1);
        slv_word = vecs[0].rx;
        push_init();
        push_poll(vecs[0].rx);
        wait_dv(ok);
        check("retry_dv_seen", 48'(ok), 48'd1);
        drain_bus("retry");
        check("retry_wii_data", wii_data, vecs[0].exp);
        check("retry_error_clear", 48'(error), 48'd0);
`else
        repeat (8) @(posedge clock);
        #1;
        check("nack_stop", 48'(stop_cnt), 48'(stop_before + 1));
        check("nack_no_dv", 48'(dv_cnt), 48'(dv_before));
        busy = 0;
        repeat (1000) begin
            @(posedge clock); #1;
            if (scl_oe !== 1'b0 || sda_oe !== 1'b0) busy++;
        end
        check("fault_idle", 48'(busy), 48'd0);
        check("fault_error_held", 48'(error), 48'd1);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
